// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared types and constants for the switch conditioning stage
//
// Purpose: debounce FSM state encoding and the number of switch channels,
//          shared by debounce_ch and switch_conditioner.
// Ports:   none (package).

package lab_pkg;

  typedef enum logic {IDLE, COUNT} deb_state_t;

  localparam int NUM_SW = 3;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one switch channel: 2-flop synchroniser plus debounce FSM
//
// Purpose: synchronises one raw switch to clk_i and only accepts a new level
//          once it has been seen for DEBOUNCE_CYCLES consecutive synchronised
//          cycles. Any return to the current level restarts the count from zero.
// Ports:
//   clk_i     in   system clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   sw_i      in   raw asynchronous switch level
//   stable_o  out  registered debounced level
//   toggle_o  out  high in the cycle whose closing edge flips stable_o

module debounce_ch
  import lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic stable_o,
  output logic toggle_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  deb_state_t       state_q;

  logic differ_d;
  logic toggle_d;

  assign differ_d = (s2_q != stable_q);

  // With a single-cycle debounce the first differing sample is already
  // enough, so IDLE toggles directly and COUNT is never entered.
  always_comb begin
    toggle_d = 1'b0;
    if (differ_d) begin
      if (state_q == COUNT) toggle_d = (cnt_q == LAST_CNT);
      else                  toggle_d = (DEBOUNCE_CYCLES == 1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= IDLE;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
      case (state_q)
        IDLE: begin
          if (differ_d) begin
            if (toggle_d) begin
              stable_q <= ~stable_q;
            end else begin
              state_q <= COUNT;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        COUNT: begin
          if (!differ_d) begin
            // Glitch: discard all accumulated credit.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (toggle_d) begin
            stable_q <= ~stable_q;
            state_q  <= IDLE;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign stable_o = stable_q;
  assign toggle_o = toggle_d;

endmodule

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - synchronise and debounce three board switches
//
// Purpose: three independent debounce channels feeding clean a/b/c levels,
//          plus a registered one-cycle 'changed' strobe on any update.
//          Optional macro SWITCH_COND_EDGE_EN adds per-channel rise/fall pulses.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   sw_in    in   raw switches: bit0 -> a, bit1 -> b, bit2 -> c
//   a, b, c  out  debounced levels
//   changed  out  one-cycle pulse, coincident with any output update
//   rise     out  (SWITCH_COND_EDGE_EN) per-channel 0->1 pulse
//   fall     out  (SWITCH_COND_EDGE_EN) per-channel 1->0 pulse

module switch_conditioner
  import lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_in,
  output logic              a,
  output logic              b,
  output logic              c,
`ifdef SWITCH_COND_EDGE_EN
  output logic [NUM_SW-1:0] rise,
  output logic [NUM_SW-1:0] fall,
`endif
  output logic              changed
);

  logic [NUM_SW-1:0] stable;
  logic [NUM_SW-1:0] toggle;
  logic              changed_q;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk_i   (clk),
      .rst_i   (rst),
      .sw_i    (sw_in[i]),
      .stable_o(stable[i]),
      .toggle_o(toggle[i])
    );
  end

  // Registered from the channels' toggle flags so the strobe lands on the
  // same edge as the level change; simultaneous toggles merge into one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= |toggle;
  end

`ifdef SWITCH_COND_EDGE_EN
  logic [NUM_SW-1:0] rise_q;
  logic [NUM_SW-1:0] fall_q;

  // The pre-toggle level tells the direction of the coming edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= toggle & ~stable;
      fall_q <= toggle & stable;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

  assign a       = stable[0];
  assign b       = stable[1];
  assign c       = stable[2];
  assign changed = changed_q;

endmodule
